// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the dtcore32 MMIO bridge: response codes,
// FSM state encodings and the MMIO window bounds.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] MMIO_BASE = 32'h0000_2400;
  localparam logic [31:0] MMIO_END  = 32'h0000_2410;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_t;

  // SLVERR and DECERR both report an error to the core.
  function automatic logic resp_is_err(input logic [1:0] resp);
    case (resp)
      RESP_OKAY, RESP_EXOKAY:   resp_is_err = 1'b0;
      RESP_SLVERR, RESP_DECERR: resp_is_err = 1'b1;
      default:                  resp_is_err = 1'b0;
    endcase
  endfunction

  function automatic logic in_mmio(input logic [31:0] addr);
    in_mmio = (addr >= MMIO_BASE) && (addr < MMIO_END);
  endfunction

endpackage

// File: rtl/axil_master.sv
// Core MMIO port to AXI4-Lite manager bridge. Independent read and write
// engines; each core request becomes exactly one AXI4-Lite transaction.
module axil_master
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START_READ,
  input  logic                      START_WRITE,
  input  logic [ADDR_WIDTH-1:0]     TRANSACTION_RADDR,
  input  logic [ADDR_WIDTH-1:0]     TRANSACTION_WRADDR,
  input  logic [DATA_WIDTH-1:0]     TRANSACTION_WRDATA,
  input  logic [3:0]                TRANSACTION_WSTRB,
  output logic [DATA_WIDTH-1:0]     TRANSACTION_RDATA,
  output logic                      BUSY_READ,
  output logic                      BUSY_WRITE,
  output logic                      DONE_READ,
  output logic                      DONE_WRITE,
  output logic                      ERR_READ,
  output logic                      ERR_WRITE,
  output logic [ADDR_WIDTH-1:0]     M_AWADDR,
  output logic [2:0]                M_AWPROT,
  output logic                      M_AWVALID,
  input  logic                      M_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
  output logic                      M_WVALID,
  input  logic                      M_WREADY,
  input  logic [1:0]                M_BRESP,
  input  logic                      M_BVALID,
  output logic                      M_BREADY,
  output logic [ADDR_WIDTH-1:0]     M_ARADDR,
  output logic [2:0]                M_ARPROT,
  output logic                      M_ARVALID,
  input  logic                      M_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_RDATA,
  input  logic [1:0]                M_RRESP,
  input  logic                      M_RVALID,
  output logic                      M_RREADY
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  wr_state_t wr_state;
  rd_state_t rd_state;

  assign M_AWPROT = 3'b000;
  assign M_ARPROT = 3'b000;

  // Write engine: AW and W complete independently, then wait for B.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_state   <= W_IDLE;
      M_AWADDR   <= '0;
      M_WDATA    <= '0;
      M_WSTRB    <= '0;
      M_AWVALID  <= 1'b0;
      M_WVALID   <= 1'b0;
      M_BREADY   <= 1'b0;
      BUSY_WRITE <= 1'b0;
      DONE_WRITE <= 1'b0;
      ERR_WRITE  <= 1'b0;
    end else begin
      DONE_WRITE <= 1'b0;
      case (wr_state)
        W_IDLE: begin
          if (START_WRITE) begin
            M_AWADDR   <= TRANSACTION_WRADDR;
            M_WDATA    <= TRANSACTION_WRDATA;
            M_WSTRB    <= STRB_WIDTH'(TRANSACTION_WSTRB);
            M_AWVALID  <= 1'b1;
            M_WVALID   <= 1'b1;
            BUSY_WRITE <= 1'b1;
            wr_state   <= W_ADDR_DATA;
          end
        end
        W_ADDR_DATA: begin
          if (M_AWREADY) M_AWVALID <= 1'b0;
          if (M_WREADY)  M_WVALID  <= 1'b0;
          // A channel is finished if it already handshook or does so now.
          if ((!M_AWVALID || M_AWREADY) && (!M_WVALID || M_WREADY)) begin
            M_BREADY <= 1'b1;
            wr_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (M_BVALID) begin
            M_BREADY   <= 1'b0;
            DONE_WRITE <= 1'b1;
            ERR_WRITE  <= resp_is_err(M_BRESP);
            BUSY_WRITE <= 1'b0;
            wr_state   <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read engine: AR handshake, then capture R data.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rd_state          <= R_IDLE;
      M_ARADDR          <= '0;
      M_ARVALID         <= 1'b0;
      M_RREADY          <= 1'b0;
      TRANSACTION_RDATA <= '0;
      BUSY_READ         <= 1'b0;
      DONE_READ         <= 1'b0;
      ERR_READ          <= 1'b0;
    end else begin
      DONE_READ <= 1'b0;
      case (rd_state)
        R_IDLE: begin
          if (START_READ) begin
            M_ARADDR  <= TRANSACTION_RADDR;
            M_ARVALID <= 1'b1;
            BUSY_READ <= 1'b1;
            rd_state  <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (M_ARREADY) begin
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b1;
            rd_state  <= R_DATA;
          end
        end
        R_DATA: begin
          if (M_RVALID) begin
            M_RREADY          <= 1'b0;
            TRANSACTION_RDATA <= M_RDATA;
            DONE_READ         <= 1'b1;
            ERR_READ          <= resp_is_err(M_RRESP);
            BUSY_READ         <= 1'b0;
            rd_state          <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master: table of single/concurrent transactions
// against a cycle-scheduled slave, plus reset and mid-transaction reset sequences.
module tb_axil_master;
  import axil_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START_READ, START_WRITE;
  logic [31:0] TRANSACTION_RADDR, TRANSACTION_WRADDR, TRANSACTION_WRDATA;
  logic [3:0]  TRANSACTION_WSTRB;
  logic [31:0] TRANSACTION_RDATA;
  logic        BUSY_READ, BUSY_WRITE, DONE_READ, DONE_WRITE, ERR_READ, ERR_WRITE;
  logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
  logic [2:0]  M_AWPROT, M_ARPROT;
  logic [3:0]  M_WSTRB;
  logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
  logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
  logic [1:0]  M_BRESP, M_RRESP;

  always #5 CLK = ~CLK;

  axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST),
    .START_READ(START_READ), .START_WRITE(START_WRITE),
    .TRANSACTION_RADDR(TRANSACTION_RADDR), .TRANSACTION_WRADDR(TRANSACTION_WRADDR),
    .TRANSACTION_WRDATA(TRANSACTION_WRDATA), .TRANSACTION_WSTRB(TRANSACTION_WSTRB),
    .TRANSACTION_RDATA(TRANSACTION_RDATA),
    .BUSY_READ(BUSY_READ), .BUSY_WRITE(BUSY_WRITE),
    .DONE_READ(DONE_READ), .DONE_WRITE(DONE_WRITE),
    .ERR_READ(ERR_READ), .ERR_WRITE(ERR_WRITE),
    .M_AWADDR(M_AWADDR), .M_AWPROT(M_AWPROT), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARPROT(M_ARPROT), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  // *_at fields are cycle offsets from the START cycle at which the slave
  // raises that READY/VALID; exp_* are hand-derived results.
  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    int          aw_at;
    int          w_at;
    int          b_at;
    int          dup_wr_at;
    int          exp_wdone;
    logic        exp_werr;
    int          exp_awv;
    int          exp_wv;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          ar_at;
    int          r_at;
    int          exp_rdone;
    logic        exp_rerr;
    int          exp_arv;
  } vec_t;

  vec_t        vecs[6];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] prev_rdata;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    START_READ = 1'b0; START_WRITE = 1'b0;
    TRANSACTION_RADDR = '0; TRANSACTION_WRADDR = '0;
    TRANSACTION_WRDATA = '0; TRANSACTION_WSTRB = '0;
    M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BVALID = 1'b0; M_BRESP = 2'b00;
    M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RRESP = 2'b00; M_RDATA = '0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int wdone_n = 0, rdone_n = 0, wdone_rel = -1, rdone_rel = -1;
    int awv_n = 0, wv_n = 0, arv_n = 0;
    logic werr = 1'b0, rerr = 1'b0, wbusy_done = 1'b1, wbusy1 = 1'b0, rbusy1 = 1'b0;
    logic aw_hs = 1'b0, w_hs = 1'b0, b_hs = 1'b0, ar_hs = 1'b0, r_hs = 1'b0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0, rdata_done = '0, rhold = '0;
    logic [3:0]  cap_wstrb = '0;
    string p;
    p = $sformatf("v%0d_", idx);
    @(posedge CLK); #1;
    START_WRITE = v.wr; TRANSACTION_WRADDR = v.waddr;
    TRANSACTION_WRDATA = v.wdata; TRANSACTION_WSTRB = v.wstrb;
    START_READ = v.rd; TRANSACTION_RADDR = v.raddr;
    for (int rel = 1; rel <= 11; rel++) begin
      @(posedge CLK); #1;
      if (DONE_WRITE) begin
        wdone_n++; wdone_rel = rel; werr = ERR_WRITE; wbusy_done = BUSY_WRITE;
      end
      if (DONE_READ) begin
        rdone_n++; rdone_rel = rel; rerr = ERR_READ; rdata_done = TRANSACTION_RDATA;
      end
      if (M_AWVALID) awv_n++;
      if (M_WVALID) wv_n++;
      if (M_ARVALID) arv_n++;
      if (rel == 1) begin wbusy1 = BUSY_WRITE; rbusy1 = BUSY_READ; end
      if (v.rd && rel == v.exp_rdone - 1) rhold = TRANSACTION_RDATA;
      START_READ = 1'b0;
      START_WRITE = (rel == v.dup_wr_at);
      TRANSACTION_WRADDR = 32'h0000_2FF0; TRANSACTION_WRDATA = 32'hFFFF_FFFF;
      M_AWREADY = v.wr && (rel >= v.aw_at) && !aw_hs;
      M_WREADY  = v.wr && (rel >= v.w_at) && !w_hs;
      M_BVALID  = v.wr && (rel >= v.b_at) && !b_hs;
      M_BRESP   = v.bresp;
      M_ARREADY = v.rd && (rel >= v.ar_at) && !ar_hs;
      M_RVALID  = v.rd && (rel >= v.r_at) && !r_hs;
      M_RRESP   = v.rresp;
      M_RDATA   = v.rdata;
      if (M_AWVALID && M_AWREADY) begin aw_hs = 1'b1; cap_awaddr = M_AWADDR; end
      if (M_WVALID && M_WREADY) begin w_hs = 1'b1; cap_wdata = M_WDATA; cap_wstrb = M_WSTRB; end
      if (M_BVALID && M_BREADY) b_hs = 1'b1;
      if (M_ARVALID && M_ARREADY) begin ar_hs = 1'b1; cap_araddr = M_ARADDR; end
      if (M_RVALID && M_RREADY) r_hs = 1'b1;
    end
    idle_inputs();
    if (v.wr) begin
      chk({p, "wdone_count"}, 64'(wdone_n), 64'd1);
      chk({p, "wdone_cycle"}, 64'(wdone_rel), 64'(v.exp_wdone));
      chk({p, "werr"}, 64'(werr), 64'(v.exp_werr));
      chk({p, "awvalid_cycles"}, 64'(awv_n), 64'(v.exp_awv));
      chk({p, "wvalid_cycles"}, 64'(wv_n), 64'(v.exp_wv));
      chk({p, "awaddr"}, 64'(cap_awaddr), 64'(v.waddr));
      chk({p, "wdata"}, 64'(cap_wdata), 64'(v.wdata));
      chk({p, "wstrb"}, 64'(cap_wstrb), 64'(v.wstrb));
      chk({p, "busy_write_start"}, 64'(wbusy1), 64'd1);
      chk({p, "busy_write_done"}, 64'(wbusy_done), 64'd0);
    end else begin
      chk({p, "no_wdone"}, 64'(wdone_n + awv_n), 64'd0);
    end
    if (v.rd) begin
      chk({p, "rdone_count"}, 64'(rdone_n), 64'd1);
      chk({p, "rdone_cycle"}, 64'(rdone_rel), 64'(v.exp_rdone));
      chk({p, "rerr"}, 64'(rerr), 64'(v.exp_rerr));
      chk({p, "rdata"}, 64'(rdata_done), 64'(v.rdata));
      chk({p, "rdata_hold"}, 64'(rhold), 64'(prev_rdata));
      chk({p, "arvalid_cycles"}, 64'(arv_n), 64'(v.exp_arv));
      chk({p, "araddr"}, 64'(cap_araddr), 64'(v.raddr));
      chk({p, "busy_read_start"}, 64'(rbusy1), 64'd1);
      prev_rdata = v.rdata;
    end else begin
      chk({p, "no_rdone"}, 64'(rdone_n + arv_n), 64'd0);
    end
  endtask

  initial begin
    //         wr rd waddr         wdata          strb  bresp aw w b dup wd we awv wv raddr        rdata          rresp ar r rd re arv
    vecs[0] = '{1'b1, 1'b0, 32'h2404, 32'hDEADBEEF, 4'hF, 2'b00, 1, 1, 2, 0, 3, 1'b0, 1, 1, 32'h0, 32'h0, 2'b00, 0, 0, 0, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b0, 32'h2400, 32'hCAFEF00D, 4'h3, 2'b10, 1, 4, 6, 0, 7, 1'b1, 1, 4, 32'h0, 32'h0, 2'b00, 0, 0, 0, 1'b0, 0};
    vecs[2] = '{1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 1'b0, 0, 0, 32'h2408, 32'h12345678, 2'b00, 4, 6, 7, 1'b0, 4};
    vecs[3] = '{1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 1'b0, 0, 0, 32'h240C, 32'hA5A50F0F, 2'b11, 1, 2, 3, 1'b1, 1};
    vecs[4] = '{1'b1, 1'b1, 32'h2404, 32'h11223344, 4'h5, 2'b01, 2, 1, 3, 1, 4, 1'b0, 2, 1, 32'h2400, 32'h0BADF00D, 2'b10, 1, 2, 3, 1'b1, 1};
    vecs[5] = '{1'b1, 1'b0, 32'h2408, 32'h00000000, 4'h0, 2'b00, 3, 1, 4, 0, 5, 1'b0, 3, 1, 32'h0, 32'h0, 2'b00, 0, 0, 0, 1'b0, 0};

    idle_inputs();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      M_AWREADY = 1'($urandom); M_WREADY = 1'($urandom); M_BVALID = 1'($urandom);
      M_BRESP = 2'($urandom); M_ARREADY = 1'($urandom); M_RVALID = 1'($urandom);
      M_RRESP = 2'($urandom); M_RDATA = $urandom;
    end
    chk("rst_ctrl", 64'({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY,
                         BUSY_READ, BUSY_WRITE, DONE_READ, DONE_WRITE, ERR_READ, ERR_WRITE}), 64'd0);
    chk("rst_rdata", 64'(TRANSACTION_RDATA), 64'd0);
    chk("rst_addr", {M_AWADDR, M_ARADDR}, 64'd0);
    chk("rst_wdata", {M_WDATA, 28'd0, M_WSTRB}, 64'd0);
    chk("rst_prot", 64'({M_AWPROT, M_ARPROT}), 64'd0);
    chk("rst_fsm", 64'({dut.wr_state == W_IDLE, dut.rd_state == R_IDLE}), 64'd3);
    idle_inputs();
    RST = 1'b1;
    prev_rdata = '0;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset while the write is stuck waiting on AWREADY/WREADY.
    @(posedge CLK); #1;
    START_WRITE = 1'b1; TRANSACTION_WRADDR = 32'h2404;
    TRANSACTION_WRDATA = 32'h55AA55AA; TRANSACTION_WSTRB = 4'hF;
    @(posedge CLK); #1;
    START_WRITE = 1'b0;
    chk("midrst_pre_valids", 64'({M_AWVALID, M_WVALID, BUSY_WRITE}), 64'd7);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    chk("midrst_valids", 64'({M_AWVALID, M_WVALID, M_BREADY, BUSY_WRITE}), 64'd0);
    chk("midrst_rdata", 64'(TRANSACTION_RDATA), 64'd0);
    chk("midrst_fsm", 64'(dut.wr_state == W_IDLE), 64'd1);
    prev_rdata = '0;
    run_vec(6, vecs[2]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axil_master.md
# axil_master

Bridges the dtcore32 MMIO transaction port to an AXI4-Lite manager interface. Each core-side read or write request becomes one AXI4-Lite transaction. The block returns busy/done status and read data to the core. It sits between the core's AXIL_* port and the SoC interconnect that serves the MMIO window (0x2400–0x240F).

## Interface
- ADDR_WIDTH, 32, AXI and transaction address width
- DATA_WIDTH, 32, data width; only 32 supported; strobe width DATA_WIDTH/8
- One clock; reset is synchronous and active-low.
- CLK  in  1  clock
- RST  in  1  synchronous active-low reset
- START_READ  in  1  one-cycle read request from core
- START_WRITE  in  1  one-cycle write request from core
- TRANSACTION_RADDR  in  ADDR_WIDTH  read address, sampled with START_READ
- TRANSACTION_WRADDR  in  ADDR_WIDTH  write address, sampled with START_WRITE
- TRANSACTION_WRDATA  in  DATA_WIDTH  write data, sampled with START_WRITE
- TRANSACTION_WSTRB  in  4  byte strobes, sampled with START_WRITE
- TRANSACTION_RDATA  out  DATA_WIDTH  last completed read data
- BUSY_READ / BUSY_WRITE  out  1  channel has a transaction outstanding
- DONE_READ / DONE_WRITE  out  1  one-cycle completion pulse
- ERR_READ / ERR_WRITE  out  1  RRESP/BRESP[1] of the completing transaction; valid with DONE
- M_AWADDR, M_AWVALID (out), M_AWREADY (in): write address channel; M_AWPROT out 3, tied 3'b000
- M_WDATA, M_WSTRB, M_WVALID (out), M_WREADY (in): write data channel
- M_BRESP in 2, M_BVALID in 1, M_BREADY out 1: write response channel
- M_ARADDR, M_ARVALID (out), M_ARREADY (in): read address channel; M_ARPROT out 3, tied 3'b000
- M_RDATA in DATA_WIDTH, M_RRESP in 2, M_RVALID in 1, M_RREADY out 1: read data channel

## Operation
- Read and write engines are independent FSMs. Both may be active at once. There is no ordering between them.
- Write FSM: W_IDLE → W_ADDR_DATA → W_RESP → W_IDLE.
  - W_IDLE: on START_WRITE, register addr/data/strb, assert AWVALID and WVALID, set BUSY_WRITE.
  - W_ADDR_DATA: AWVALID drops the cycle after its own handshake, independently of WVALID, and vice versa. When both handshakes are complete (in the same or different cycles), go to W_RESP.
  - W_RESP: BREADY=1. On BVALID, pulse DONE_WRITE, set ERR_WRITE=BRESP[1], clear BUSY_WRITE, go to W_IDLE.
- Read FSM: R_IDLE → R_ADDR → R_DATA → R_IDLE.
  - R_IDLE: on START_READ, register address, assert ARVALID.
  - R_ADDR: on ARREADY, go to R_DATA.
  - R_DATA: RREADY=1. On RVALID, capture RDATA into TRANSACTION_RDATA, pulse DONE_READ, set ERR_READ=RRESP[1], go to R_IDLE.
- A START on a channel that is busy is ignored. Verification checks that the core never does this, but the ignore behaviour is still required.
- An error response does not retry. Read data is still captured.
- TRANSACTION_RDATA holds its value until the next read completes.
- VALID signals, once raised, never drop before their handshake completes (AXI rule).

## Timing
- Reset values: all VALID/READY outputs 0, BUSY 0, DONE 0, ERR 0, TRANSACTION_RDATA 0, addresses/data/strobes 0, FSMs in IDLE.
- START in cycle N: AWVALID/WVALID (or ARVALID) and BUSY are high in N+1. All outputs are registered.
- Zero-wait slave, write: AW and W handshake in N+1; BREADY high in N+2; with BVALID in N+2, DONE_WRITE is high in N+3. Minimum write latency is 3 cycles from START to DONE.
- Zero-wait slave, read: ARREADY in N+1; RVALID in N+2; DONE_READ and new TRANSACTION_RDATA are visible in N+3.
- BUSY deasserts in the same cycle DONE pulses. A new START accepted in that cycle starts the next transaction; back-to-back issue rate is one transaction per 3 cycles.
- BREADY/RREADY deassert the cycle after the response handshake.
- Simultaneous START_READ and START_WRITE: both accepted in the same cycle.
- Reset asserted mid-transaction: next cycle all outputs take reset values; the outstanding transaction is abandoned. The interconnect is reset by the same RST.

## Structure
- Shared package axil_pkg holds:
  - the AXI resp encodings (OKAY=2'b00, EXOKAY, SLVERR=2'b10, DECERR);
  - the wr_state_t and rd_state_t enums;
  - MMIO_BASE=32'h2400 and MMIO_END=32'h2410.
- Single module; no sub-module. The two FSMs are separate always blocks in the same file.

## Test plan
- Reset: hold RST=0 for 3 cycles with random AXI inputs → every output 0, both FSMs IDLE.
- Zero-wait write: START_WRITE, WRADDR=0x2404, WRDATA=0xDEADBEEF, WSTRB=0xF → AW/W handshake at N+1, DONE_WRITE at N+3, ERR_WRITE=0.
- Skewed write: AWREADY at N+1, WREADY at N+4, BVALID at N+6 with BRESP=2'b10 → AWVALID drops at N+2, WVALID held until N+4, DONE_WRITE at N+7, ERR_WRITE=1.
- Read with backpressure: START_READ with addr 0x2408; ARREADY delayed 3 cycles; RVALID with RDATA=0x12345678 2 cycles later → TRANSACTION_RDATA=0x12345678, DONE_READ exactly once, ARVALID stable while stalled.
- Concurrency and ignore: START_READ and START_WRITE in the same cycle, then a second START_WRITE while BUSY_WRITE=1 → both channels complete, and only one AW transaction appears on the bus.
- Mid-reset: RST=0 while in W_ADDR_DATA with AWREADY=0 → AWVALID=WVALID=0 next cycle; after reset a fresh read completes normally.
